// File: rtl/ram_rr_arbiter.sv
// Two-client round-robin arbiter for a single-port synchronous-read RAM.
// Burst ownership is bounded while the other client waits.
module ram_rr_arbiter #(
    parameter int AWIDTH    = 3,
    parameter int DWIDTH    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [DWIDTH-1:0] din0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DWIDTH-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] din1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DWIDTH-1:0] rdata1,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

    owner_t        owner;
    logic [CW-1:0] cnt;
    logic          last;
    logic          rv0_q;
    logic          rv1_q;
    logic          g0;
    logic          g1;
    logic          below_max;

    assign below_max = (cnt < CMAX);

    // The owner keeps the RAM until its burst is spent and the other client waits.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        unique case (owner)
            IDLE: begin
                g0 = req0 & (~req1 | last);
                g1 = req1 & (~req0 | ~last);
            end
            OWN0: begin
                g0 = req0 & (below_max | ~req1);
                g1 = ~g0 & req1;
            end
            OWN1: begin
                g1 = req1 & (below_max | ~req0);
                g0 = ~g1 & req0;
            end
            default: begin
                g0 = 1'b0;
                g1 = 1'b0;
            end
        endcase
        if (reset) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end
    end

    assign gnt0     = g0;
    assign gnt1     = g1;
    assign ram_addr = g1 ? addr1 : addr0;
    assign ram_din  = g1 ? din1 : din0;
    assign ram_we   = (g0 & we0) | (g1 & we1);

    always_ff @(posedge clock) begin
        if (reset) begin
            owner <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
        end else begin
            rv0_q <= g0 & ~we0;
            rv1_q <= g1 & ~we1;
            if (g0) begin
                owner <= OWN0;
                last  <= 1'b0;
                if (owner == OWN0)
                    cnt <= below_max ? cnt + 1'b1 : cnt;
                else
                    cnt <= CW'(1);
            end else if (g1) begin
                owner <= OWN1;
                last  <= 1'b1;
                if (owner == OWN1)
                    cnt <= below_max ? cnt + 1'b1 : cnt;
                else
                    cnt <= CW'(1);
            end else begin
                owner <= IDLE;
                cnt   <= '0;
            end
        end
    end

    // A read granted just before reset must not report data during reset.
    assign rvalid0 = rv0_q & ~reset;
    assign rvalid1 = rv1_q & ~reset;
    assign rdata0  = ram_dout;
    assign rdata1  = ram_dout;

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the team's single-port synchronous-read RAM: one address bus, separate write/read data, write on clock rising edge, read data one cycle after the address is latched.
- Multiplexes two client ports onto the RAM port.
- Supports bounded burst ownership, so a requester keeps the RAM for back-to-back accesses up to a limit.
- Returns read data to the originating client with a registered valid strobe.

Parameters:
AWIDTH, 3, address width; must match the RAM instance
DWIDTH, 32, data width; must match the RAM instance
MAX_BURST, 4, max consecutive grants to one owner while the other requests; must be >= 1

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  client 0 access request, held until granted
we0  input  1  client 0 write enable (1 = write, 0 = read)
addr0  input  AWIDTH  client 0 address
din0  input  DWIDTH  client 0 write data
gnt0  output  1  client 0 access issued this cycle (combinational)
rvalid0  output  1  client 0 read data valid (registered)
rdata0  output  DWIDTH  client 0 read data
req1, we1, addr1, din1, gnt1, rvalid1, rdata1  same as client 0, for client 1
ram_addr  output  AWIDTH  to RAM addr
ram_din  output  DWIDTH  to RAM din
ram_we  output  1  to RAM we
ram_dout  input  DWIDTH  from RAM dout

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Registered state:
  - FSM owner: IDLE, OWN0, OWN1.
  - Burst counter cnt, width clog2(MAX_BURST+1).
  - Priority pointer last: id of the most recently granted client.
  - rvalid0/rvalid1.
- Reset values: owner = IDLE, cnt = 0, last = 1 (client 0 wins the first tie), rvalid0 = rvalid1 = 0.
- gnt0/gnt1 are forced 0 while reset is high; ram_we is therefore 0.
- Grant decision, evaluated every cycle from current state and req inputs:
  - IDLE:
    - Only one req high: grant it.
    - Both high: grant the client != last.
    - Neither high: no grant, stay IDLE.
  - OWNx:
    - reqx high AND (cnt < MAX_BURST OR other req low): grant x again; cnt = min(cnt+1, MAX_BURST).
    - Otherwise, other req high: grant other; go to OWN(other), cnt = 1 (switch with no idle cycle).
    - Otherwise: no grant; go to IDLE, cnt = 0.
  - Any grant from IDLE: go to OWNx, cnt = 1.
  - Every grant sets last to the granted id.
- At most one gnt is high per cycle; the gnt0 & gnt1 invariant must never be violated.
- RAM drive (combinational):
  - Granted x: ram_addr = addrx, ram_din = dinx, ram_we = wex.
  - No grant: ram_addr = addr0, ram_din = din0, ram_we = 0.
- Access completion:
  - A client samples gnt and, if its request completed, may drop req or present the next access in the following cycle.
  - A write completes at the granted rising edge.
- Read return:
  - rvalidx <= gntx & ~wex (registered), i.e. rvalid is high exactly one cycle after a granted read.
  - rdata0 = rdata1 = ram_dout, passed through unregistered; valid only when the matching rvalid is high.
  - Back-to-back reads produce back-to-back rvalid.
- Write then read, same address, consecutive cycles: the read returns the new data, because the RAM output is an asynchronous array read through the latched address.
- Reset mid-operation: rvalid for a read granted in the cycle before reset is not asserted; owner returns to IDLE.
- No contention: an owner may hold the RAM indefinitely; cnt saturates at MAX_BURST.

Test Plan:
1. After reset, client 0 writes 0x0000_00A5 to addr 5, then reads addr 5 → gnt0 high in both request cycles; rvalid0 = 1 with rdata0 = 0x0000_00A5 the cycle after the read grant; rvalid1 stays 0.
2. MAX_BURST = 4, req0 and req1 held high continuously from IDLE → grant sequence 0,0,0,0,1,1,1,1,0,… with no idle cycle between owners.
3. req0 and req1 rise together in the first cycle after reset → client 0 granted. Release both, return to IDLE, raise both again → client 1 granted.
4. req1 alone high for 10 cycles of reads to addr 0..7 (wrapping to 0,1) → gnt1 high all 10 cycles; rvalid1 high cycles 2–11 with the matching data.
5. Client 0 writes 0xDEAD_BEEF to addr 3; client 1's read of addr 3 is granted the next cycle → rdata1 = 0xDEAD_BEEF with rvalid1 high.
6. Client 0 read granted at cycle N, reset asserted at cycle N+1 → rvalid0 = 0 at N+1; gnt0 = gnt1 = 0 and ram_we = 0 while reset is high; first grant after reset goes to client 0 on a tie.
